// File: rtl/demux_1_8_sequencer_pkg.sv
// Shared widths and state encoding for the 1:8 demux sequencer and its
// round-robin picker.
package demux_seq_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int CNT_W  = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SETUP = 2'd1;
  localparam state_t HOLD  = 2'd2;
  localparam state_t GAP   = 2'd3;

endpackage

// File: rtl/demux_1_8_sequencer_if.sv
// Request handshake, scan control and demux drive lines of the sequencer.
interface demux_1_8_sequencer_if;
  import demux_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CH_W-1:0]   in_chan;
  logic              in_data;
  logic              scan_en;
  logic [NUM_CH-1:0] scan_mask;
  logic              sel_a;
  logic              sel_b;
  logic              sel_c;
  logic              d_out;
  logic              busy;
  logic [CH_W-1:0]   cur_chan;
  logic              done;

  modport master (
    output in_valid, in_chan, in_data, scan_en, scan_mask,
    input  in_ready, sel_a, sel_b, sel_c, d_out, busy, cur_chan, done
  );

  modport slave (
    input  in_valid, in_chan, in_data, scan_en, scan_mask,
    output in_ready, sel_a, sel_b, sel_c, d_out, busy, cur_chan, done
  );

endinterface

// File: rtl/demux_1_8_sequencer_rr_pick8.sv
// Combinational round-robin picker: first set mask bit strictly after ptr,
// wrapping 7->0, with ptr itself as the last candidate.
module rr_pick8
  import demux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   next,
  output logic              any
);

  logic [CH_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    next = ptr;
    idx  = ptr;
    any  = |mask;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = ptr + i[CH_W-1:0];
      if (mask[idx]) begin
        next = idx;
      end
    end
  end

endmodule

// File: rtl/demux_1_8_sequencer.sv
// Drives the select and data lines of a 1:8 demux as setup/hold/gap phases
// so the selects only move while D is low.
module demux_1_8_sequencer
  import demux_seq_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 4,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_1_8_sequencer_if.slave bus
);

  generate
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255) begin : g_bad_setup
      $error("SETUP_CYCLES must be in 1..255");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("HOLD_CYCLES must be in 1..255");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("GAP_CYCLES must be in 0..255");
    end
  endgenerate

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [CH_W-1:0]   chan_q, chan_n;
  logic              data_q, data_n;
  logic [CH_W-1:0]   ptr_q, ptr_n;
  logic              d_out_q, busy_q, done_q;
  logic [CH_W-1:0]   pick_next;
  logic              pick_any;

  rr_pick8 u_pick (
    .mask (bus.scan_mask),
    .ptr  (ptr_q),
    .next (pick_next),
    .any  (pick_any)
  );

  // Handshake requests win over scan; scan only advances its pointer on a grant.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    chan_n  = chan_q;
    data_n  = data_q;
    ptr_n   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          chan_n  = bus.in_chan;
          data_n  = bus.in_data;
          cnt_n   = SETUP_LD;
          state_n = SETUP;
        end else if (bus.scan_en && pick_any) begin
          chan_n  = pick_next;
          data_n  = 1'b1;
          ptr_n   = pick_next;
          cnt_n   = SETUP_LD;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          cnt_n   = HOLD_LD;
          state_n = HOLD;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            cnt_n   = GAP_LD;
            state_n = GAP;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they align with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      data_q  <= 1'b0;
      ptr_q   <= CH_W'(NUM_CH - 1);
      d_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      chan_q  <= chan_n;
      data_q  <= data_n;
      ptr_q   <= ptr_n;
      d_out_q <= (state_n == HOLD) && data_n;
      busy_q  <= (state_n != IDLE);
      done_q  <= (state_n == HOLD) && (cnt_n == '0);
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.sel_a    = chan_q[2];
  assign bus.sel_b    = chan_q[1];
  assign bus.sel_c    = chan_q[0];
  assign bus.cur_chan = chan_q;
  assign bus.d_out    = d_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_demux_1_8_sequencer.sv
// Scoreboard bench for the demux sequencer: default timing instance plus a
// SETUP=1/HOLD=1/GAP=0 instance.
module tb_demux_1_8_sequencer;
  import demux_seq_pkg::*;

  localparam int P = 10;
  localparam int S = 1;
  localparam int H = 4;
  localparam int G = 1;

  typedef struct packed {
    logic [2:0] chan;
    logic       data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #(P/2) clk = ~clk;

  demux_1_8_sequencer_if bus ();
  demux_1_8_sequencer_if bus2 ();

  demux_1_8_sequencer #(.SETUP_CYCLES(S), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  demux_1_8_sequencer #(.SETUP_CYCLES(1), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  exp_t exp_q[$];
  exp_t exp2_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   dut2_fin = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance, in_valid still high.
  task automatic applyStimulus(input logic [2:0] ch, input logic d);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_chan  = ch;
    bus.in_data  = d;
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back('{chan: ch, data: d});
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
    end
  endtask

  task automatic waitDone(input int n);
    int seen = 0;
    int w = 0;
    while (seen < n && w < 500) begin
      @(negedge clk);
      w++;
      if (bus.done) seen++;
    end
    if (seen < n) checkOutput("done_timeout", seen, n);
  endtask

  task automatic waitIdle();
    int w = 0;
    @(negedge clk);
    while (bus.busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (bus.busy) checkOutput("idle_timeout", 1, 0);
  endtask

  // Monitor for the default instance: delivery shape, select stability, scoreboard.
  logic [2:0] mon_sel, prev_sel;
  logic       prev_d, prev_busy, glitch;
  int         ph, hi;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sel  = 3'd0;
      prev_d    = 1'b0;
      prev_busy = 1'b0;
      glitch    = 1'b0;
      ph        = 0;
      hi        = 0;
    end else begin
      mon_sel = {bus.sel_a, bus.sel_b, bus.sel_c};
      if (mon_sel != prev_sel && (bus.d_out || prev_d)) glitch = 1'b1;
      if (bus.busy) begin
        if (!prev_busy) begin
          ph = 1;
          hi = 0;
        end else begin
          ph++;
        end
        if (bus.d_out) hi++;
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("sel_at_done", mon_sel, mon_e.chan);
          checkOutput("cur_chan", bus.cur_chan, mon_e.chan);
          checkOutput("d_at_done", bus.d_out, mon_e.data);
          checkOutput("done_phase", ph, S + H);
          checkOutput("hold_len", hi, mon_e.data ? H : 0);
          checkOutput("sel_glitch", glitch, 0);
          glitch = 1'b0;
        end
      end
      if (prev_busy && !bus.busy) begin
        checkOutput("busy_len", ph, S + H + G);
        checkOutput("in_ready_after", bus.in_ready, 1);
      end
      prev_sel  = mon_sel;
      prev_d    = bus.d_out;
      prev_busy = bus.busy;
    end
  end

  // Monitor for the GAP=0 instance: done aligned with the single data cycle.
  exp_t mon_e2;
  int   last_done2 = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus2.d_out || bus2.done) checkOutput("g0_d_vs_done", bus2.d_out, bus2.done);
      if (bus2.done) begin
        if (exp2_q.size() == 0) begin
          checkOutput("g0_unexpected_done", 1, 0);
        end else begin
          mon_e2 = exp2_q.pop_front();
          checkOutput("g0_sel", {bus2.sel_a, bus2.sel_b, bus2.sel_c}, mon_e2.chan);
        end
        if (last_done2 >= 0) checkOutput("g0_done_period", cyc - last_done2, 3);
        last_done2 = cyc;
      end
    end
  end

  initial begin
    logic [2:0] ch2 [3];
    int prev_acc;
    int w;
    ch2[0] = 3'd3;
    ch2[1] = 3'd6;
    ch2[2] = 3'd1;
    prev_acc = -1;
    bus2.in_valid  = 1'b0;
    bus2.in_chan   = 3'd0;
    bus2.in_data   = 1'b0;
    bus2.scan_en   = 1'b0;
    bus2.scan_mask = 8'd0;
    @(posedge rst_n);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_chan  = ch2[i];
      bus2.in_data  = 1'b1;
      w = 0;
      while (!bus2.in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      exp2_q.push_back('{chan: ch2[i], data: 1'b1});
      @(posedge clk);
      @(negedge clk);
      if (prev_acc >= 0) checkOutput("g0_accept_period", cyc - prev_acc, 3);
      prev_acc = cyc;
    end
    bus2.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("g0_queue_empty", exp2_q.size(), 0);
    dut2_fin = 1'b1;
  end

  initial begin
    int t1;
    bus.in_valid  = 1'b0;
    bus.in_chan   = 3'd0;
    bus.in_data   = 1'b0;
    bus.scan_en   = 1'b0;
    bus.scan_mask = 8'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_sel", {bus.sel_a, bus.sel_b, bus.sel_c}, 0);
    checkOutput("rst_d_out", bus.d_out, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", bus.in_ready, 1);
    @(negedge clk);

    $display("[TB] single request chan 5");
    applyStimulus(3'd5, 1'b1);
    bus.in_valid = 1'b0;
    checkOutput("t1_sel", {bus.sel_a, bus.sel_b, bus.sel_c}, 5);
    checkOutput("t1_d_setup", bus.d_out, 0);
    checkOutput("t1_in_ready", bus.in_ready, 0);
    waitIdle();

    $display("[TB] back-to-back chan 2 then 6");
    applyStimulus(3'd2, 1'b1);
    t1 = acc_cyc;
    applyStimulus(3'd6, 1'b1);
    bus.in_valid = 1'b0;
    checkOutput("b2b_period", acc_cyc - t1, 7);
    waitIdle();

    $display("[TB] scan mask 1001_0010");
    exp_q.push_back('{chan: 3'd1, data: 1'b1});
    exp_q.push_back('{chan: 3'd4, data: 1'b1});
    exp_q.push_back('{chan: 3'd7, data: 1'b1});
    exp_q.push_back('{chan: 3'd1, data: 1'b1});
    bus.scan_mask = 8'b1001_0010;
    bus.scan_en   = 1'b1;
    waitDone(4);
    bus.scan_en = 1'b0;
    waitIdle();

    $display("[TB] request during scan");
    exp_q.push_back('{chan: 3'd4, data: 1'b1});
    bus.scan_en = 1'b1;
    @(negedge clk);
    applyStimulus(3'd3, 1'b1);
    bus.in_valid = 1'b0;
    exp_q.push_back('{chan: 3'd7, data: 1'b1});
    exp_q.push_back('{chan: 3'd1, data: 1'b1});
    waitDone(3);
    bus.scan_en = 1'b0;
    waitIdle();

    $display("[TB] data=0 delivery");
    applyStimulus(3'd0, 1'b0);
    bus.in_valid = 1'b0;
    waitIdle();

    $display("[TB] reset during hold");
    applyStimulus(3'd6, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_d", bus.d_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_d_out", bus.d_out, 0);
    checkOutput("arst_sel", {bus.sel_a, bus.sel_b, bus.sel_c}, 0);
    checkOutput("arst_busy", bus.busy, 0);
    checkOutput("arst_done", bus.done, 0);
    exp_q.delete();
    @(negedge clk);
    bus.scan_mask = 8'b0000_0101;
    bus.scan_en   = 1'b1;
    exp_q.push_back('{chan: 3'd0, data: 1'b1});
    exp_q.push_back('{chan: 3'd2, data: 1'b1});
    #2;
    rst_n = 1'b1;
    waitDone(2);
    bus.scan_en = 1'b0;
    waitIdle();

    wait (dut2_fin);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(P * 20000);
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog timeout");
  end

endmodule
